stream_pack: RTL and testbench

Narrow-to-wide stream packer on the consumer side of a valid/ready word stream, such as a FIFO's output port. It accepts one WIDTH_P-bit word per handshake and assembles LANES_P words into one packed vector, for example one systolic-array row. The vector is presented on a valid/ready output. Packets may end early via last_i; the partial vector is zero-padded and tagged with its lane count.

---
 rtl/stream_pack_if.sv | 28 ++
 rtl/stream_pack.sv | 98 +++++++++
 tb/tb_stream_pack.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pack_if.sv
// Word-in / vector-out handshake bundle for stream_pack.
// The slave modport is the packer's view; the master modport is the surrounding logic.
interface stream_pack_if #(
  parameter int LANES_P = 4,
  parameter int WIDTH_P = 8
);
  localparam int CNT_W = $clog2(LANES_P + 1);

  logic [WIDTH_P-1:0]         data_i;
  logic                       valid_i;
  logic                       last_i;
  logic                       ready_o;
  logic [LANES_P*WIDTH_P-1:0] data_o;
  logic [CNT_W-1:0]           count_o;
  logic                       last_o;
  logic                       valid_o;
  logic                       ready_i;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, count_o, last_o, valid_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, count_o, last_o, valid_o
  );
endinterface

// File: rtl/stream_pack.sv
// Narrow-to-wide packer: gathers LANES_P words (or fewer on last_i) into one
// zero-padded vector tagged with its lane count, presented on valid/ready.
module stream_pack #(
  parameter int LANES_P = 4,
  parameter int WIDTH_P = 8
) (
  input logic          clk_i,
  input logic          rst_ni,
  stream_pack_if.slave bus
);
  localparam int CNT_W = $clog2(LANES_P + 1);
  localparam int IDX_W = (LANES_P > 1) ? $clog2(LANES_P) : 1;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES_P);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [LANES_P-1:0][WIDTH_P-1:0] lanes_q, lanes_d;
  logic                            last_q, last_d;
  logic                            accept, handoff;

  // In HOLD the upstream ready is a straight combinational copy of the
  // downstream ready; register it outside if that path is too long.
  assign bus.ready_o = rst_ni && ((state_q == FILL) || bus.ready_i);
  assign accept      = bus.valid_i && bus.ready_o;
  assign handoff     = (state_q == HOLD) && bus.ready_i;
  assign fill_inc    = fill_q + ONE_C;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d = state_q;
    fill_d  = fill_q;
    count_d = count_q;
    lanes_d = lanes_q;
    last_d  = last_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          lanes_d[fill_q[IDX_W-1:0]] = bus.data_i;
          fill_d = fill_inc;
          if ((fill_inc == LANES_C) || bus.last_i) begin
            state_d = HOLD;
            count_d = fill_inc;
            last_d  = bus.last_i;
          end
        end
      end
      HOLD: begin
        if (handoff) begin
          state_d = FILL;
          fill_d  = '0;
          count_d = '0;
          lanes_d = '0;
          last_d  = 1'b0;
          // A word taken in the handoff cycle opens the next vector at lane 0.
          if (accept) begin
            lanes_d[0] = bus.data_i;
            fill_d     = ONE_C;
            if ((ONE_C == LANES_C) || bus.last_i) begin
              state_d = HOLD;
              count_d = ONE_C;
              last_d  = bus.last_i;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      fill_q  <= '0;
      count_q <= '0;
      lanes_q <= '0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      lanes_q <= lanes_d;
      last_q  <= last_d;
    end
  end

  assign bus.data_o  = lanes_q;
  assign bus.count_o = count_q;
  assign bus.last_o  = last_q;
  assign bus.valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_stream_pack.sv
// Directed + random bench for stream_pack with a 4-lane and a 1-lane instance;
// expected vectors are queued on accept and compared at each output handoff.
module tb_stream_pack;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_pack_if #(.LANES_P(4), .WIDTH_P(8)) b4 ();
  stream_pack_if #(.LANES_P(1), .WIDTH_P(8)) b1 ();

  stream_pack #(.LANES_P(4), .WIDTH_P(8)) u_dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4));
  stream_pack #(.LANES_P(1), .WIDTH_P(8)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  c;
    logic        l;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        q4[$];
  exp_t        q1[$];
  logic [31:0] acc   = '0;
  int          n_acc = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare whenever a vector is handed off at the coming edge.
  exp_t e4, e1;
  always @(negedge clk) begin
    if (rst_n && b4.valid_o && b4.ready_i) begin
      check("dut4 vector expected", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        check("dut4 data_o",  b4.data_o,  e4.d);
        check("dut4 count_o", 32'(b4.count_o), 32'(e4.c));
        check("dut4 last_o",  32'(b4.last_o),  32'(e4.l));
      end
    end
    if (rst_n && b1.valid_o && b1.ready_i) begin
      check("dut1 vector expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("dut1 data_o",  32'(b1.data_o),  e1.d);
        check("dut1 count_o", 32'(b1.count_o), 32'(e1.c));
        check("dut1 last_o",  32'(b1.last_o),  32'(e1.l));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      b1.ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send4(input logic [7:0] d, input logic l, output int waits);
    b4.data_i  = d;
    b4.last_i  = l;
    b4.valid_i = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!b4.ready_o && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!b4.ready_o) begin
      check("dut4 accept timeout", 32'(b4.ready_o), 32'd1);
      b4.valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    b4.valid_i = 1'b0;
    acc[n_acc*8 +: 8] = d;
    n_acc++;
    if (n_acc == 4 || l) begin
      q4.push_back(exp_t'{d: acc, c: 5'(n_acc), l: l});
      acc   = '0;
      n_acc = 0;
    end
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    int waits;
    b1.data_i  = d;
    b1.last_i  = l;
    b1.valid_i = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!b1.ready_o && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!b1.ready_o) begin
      check("dut1 accept timeout", 32'(b1.ready_o), 32'd1);
      b1.valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    b1.valid_i = 1'b0;
    q1.push_back(exp_t'{d: 32'(d), c: 5'd1, l: l});
  endtask

  initial begin
    int w;
    b4.data_i = '0; b4.valid_i = 1'b0; b4.last_i = 1'b0; b4.ready_i = 1'b1;
    b1.data_i = '0; b1.valid_i = 1'b0; b1.last_i = 1'b0; b1.ready_i = 1'b1;

    // Reset state
    #12;
    check("reset ready_o", 32'(b4.ready_o), 32'd0);
    check("reset valid_o", 32'(b4.valid_o), 32'd0);
    check("reset data_o",  b4.data_o, 32'd0);
    check("reset count_o", 32'(b4.count_o), 32'd0);
    check("reset last_o",  32'(b4.last_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_o after release", 32'(b4.ready_o), 32'd1);

    // Basic pack
    send4(8'h11, 1'b0, w);
    send4(8'h22, 1'b0, w);
    send4(8'h33, 1'b0, w);
    check("valid_o before 4th word", 32'(b4.valid_o), 32'd0);
    send4(8'h44, 1'b0, w);
    check("valid_o after 4th word", 32'(b4.valid_o), 32'd1);
    check("basic data_o", b4.data_o, 32'h44332211);

    // Short packet, then a fresh vector starting at lane 0
    send4(8'hAA, 1'b0, w);
    send4(8'hBB, 1'b1, w);
    check("short data_o", b4.data_o, 32'h0000BBAA);
    check("short count_o", 32'(b4.count_o), 32'd2);
    send4(8'hC1, 1'b0, w);
    send4(8'hC2, 1'b0, w);
    send4(8'hC3, 1'b0, w);
    send4(8'hC4, 1'b1, w);
    check("full+last last_o", 32'(b4.last_o), 32'd1);
    @(posedge clk);
    #1;
    check("no empty vector after full last", 32'(b4.valid_o), 32'd0);

    // Backpressure
    b4.ready_i = 1'b0;
    send4(8'hA1, 1'b0, w);
    send4(8'hA2, 1'b0, w);
    send4(8'hA3, 1'b0, w);
    send4(8'hA4, 1'b0, w);
    b4.data_i = 8'h55; b4.last_i = 1'b0; b4.valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp ready_o", 32'(b4.ready_o), 32'd0);
      check("bp valid_o", 32'(b4.valid_o), 32'd1);
      check("bp data_o stable", b4.data_o, 32'hA4A3A2A1);
    end
    @(posedge clk);
    #1;
    b4.ready_i = 1'b1;
    send4(8'h55, 1'b0, w);
    check("bp accept in handoff cycle", 32'(w), 32'd0);
    check("bp lane0 holds pending word", 32'(b4.data_o), 32'h00000055);
    check("bp back in FILL", 32'(b4.valid_o), 32'd0);
    send4(8'h66, 1'b0, w);
    send4(8'h77, 1'b0, w);
    send4(8'h88, 1'b0, w);

    // Full throughput: no bubbles with ready_i held high
    for (int i = 0; i < 16; i++) begin
      send4(8'(8'h30 + i), 1'b0, w);
      check("throughput no wait", 32'(w), 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset mid-fill discards the partial vector
    send4(8'h01, 1'b0, w);
    send4(8'h02, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset valid_o", 32'(b4.valid_o), 32'd0);
    check("midreset ready_o", 32'(b4.ready_o), 32'd0);
    acc   = '0;
    n_acc = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_o after midreset release", 32'(b4.ready_o), 32'd1);
    send4(8'h05, 1'b0, w);
    send4(8'h06, 1'b0, w);
    send4(8'h07, 1'b0, w);
    send4(8'h08, 1'b0, w);
    check("post-reset data_o", b4.data_o, 32'h08070605);

    // LANES_P=1 random traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send1(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    b1.ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("dut4 scoreboard drained", 32'(q4.size()), 32'd0);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
